sync_fifo_ctrl: RTL and testbench
=================================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock, parametrised FIFO: controller plus synchronous-read RAM.
//  Successor to the dual-clock FIFO memory for same-domain buffering.
//  Adds occupancy count, programmable almost-full/almost-empty flags,
//  selectable standard/FWFT read mode, and overflow/underflow pulses.
//  Sits between a same-clock producer and consumer; no CDC inside.
// PARAMETERS
//  D_WIDTH   32   data word width
//  A_WIDTH   8    address width; DEPTH = 2**A_WIDTH words
//  FWFT      0    0 = standard read (data 1 cycle after ren); 1 = first-word-fall-through
//  AF_LEVEL  DEPTH-4  almost_full asserted when count >= AF_LEVEL
//  AE_LEVEL  4    almost_empty asserted when count <= AE_LEVEL
// PORTS
//  clk           in   1          single clock, all logic posedge
//  rst           in   1          synchronous reset, active-high
//  wen           in   1          write request
//  wdata         in   D_WIDTH    write data
//  ren           in   1          read request (FWFT: pop/acknowledge head)
//  rdata         out  D_WIDTH    read data
//  rvalid        out  1          rdata valid (standard: 1-cycle pulse; FWFT: = !empty)
//  full          out  1          count == DEPTH
//  empty         out  1          no word readable
//  almost_full   out  1          count >= AF_LEVEL
//  almost_empty  out  1          count <= AE_LEVEL
//  count         out  A_WIDTH+1  words stored, 0..DEPTH
//  overflow      out  1          1-cycle pulse: wen while full (write dropped)
//  underflow     out  1          1-cycle pulse: ren while empty (read dropped)
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wptr/rptr/count=0, empty=1, almost_empty=1, full=0,
//    almost_full=0, rvalid=0, rdata=0, overflow=underflow=0. RAM contents not
//    cleared; reset mid-operation discards all stored words, in-flight read dropped.
//  - Pointers A_WIDTH+1 bits (wrap bit); full = MSBs differ & rest equal; wrap at DEPTH is natural.
//  - Write accepted iff wen & !full; RAM written at that edge, wptr++.
//  - Full blocks writes even if ren same cycle (no pass-through); overflow pulses.
//  - Standard: read accepted iff ren & !empty; rdata/rvalid valid next cycle; rdata
//    holds last value otherwise. Empty write+read same cycle -> read rejected, underflow.
//    Write at edge N -> empty=0 after N; ren at N+1 -> rdata at N+2.
//  - FWFT: one-entry output register prefetched from RAM whenever it is empty or
//    popped and RAM holds data. Write at N -> head on rdata, empty=0 after N+2.
//    ren & !empty pops head; next word appears next cycle if available (no bubble
//    for back-to-back pops when >=2 words). Output register counts toward count;
//    total capacity is DEPTH in both modes.
//  - count: +1 accepted write, -1 accepted read, unchanged on both; all flags
//    registered, derived from next-state count so they update with count.
//  - AF_LEVEL/AE_LEVEL outside 0..DEPTH: elaboration error ($error).
// STRUCTURE
//  - fifo_pkg: fifo_mode_e {FIFO_STD, FIFO_FWFT}; count/pointer width helper
//    functions; shared with dual-clock FIFO.
//  - One sub-module: sync_fifo_ram (simple dual-port, 1 write port, 1 sync read
//    port with read enable, one clk); controller, flags, FWFT stage in top.
// TESTING
//  1 Reset: drive traffic, assert rst 1 cycle -> count=0, empty=1, full=0, rvalid=0 next cycle.
//  2 Fill/drain, A_WIDTH=3, FWFT=0: write 0..7 -> full=1, count=8; 9th wen -> overflow
//    pulse, count stays 8; read 8 -> rdata 0..7 in order, empty=1; extra ren -> underflow.
//  3 Simultaneous: count=4, wen&ren 10 cycles -> count stays 4, data in order;
//    at full wen&ren -> read only, count 8->7; at empty wen&ren -> write only, count 0->1.
//  4 Flags: AF_LEVEL=6, AE_LEVEL=1 -> almost_full rises on 6th write, almost_empty
//    falls on 2nd write, both same cycle as count update.
//  5 FWFT=1: write 0xA5 at N -> rdata=0xA5, empty=0 after N+2; write 3 words, hold ren
//    -> rdata 3 consecutive cycles, no bubble, then empty=1.
//  6 Wrap: A_WIDTH=2, 20 random interleaved writes/reads vs scoreboard -> no loss,
//    pointers wrap cleanly, count matches model every cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the FIFO family (single- and
// dual-clock variants).
//   fifo_mode_e     read-port behaviour: standard (registered read) or FWFT
//   fifo_depth      words held by a FIFO with a given address width
//   fifo_ptr_width  pointer/count width, one extra bit to tell full from empty
//   fifo_mode       maps the integer FWFT parameter onto fifo_mode_e
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned fifo_ptr_width(input int unsigned aw);
    return aw + 32'd1;
  endfunction

  function automatic fifo_mode_e fifo_mode(input int unsigned fwft);
    return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port RAM, one clock, one write port and one
// synchronous read port with read enable.
//   clk    clock, all logic on posedge
//   rst    synchronous active-high reset of the read data register only
//   we     write enable; waddr/wdata written at the edge
//   re     read enable; rdata loads mem[raddr] at the edge, holds otherwise
// Storage is never cleared.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  localparam int unsigned Depth = fifo_depth(A_WIDTH);

  logic [D_WIDTH-1:0] mem [Depth];
  logic [D_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Output register reset maps onto the RAM primitive's output-register reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller around sync_fifo_ram.
//   clk, rst        clock and synchronous active-high reset
//   wen, wdata      write request; accepted when not full
//   ren             read request (FWFT: acknowledge/pop of the head word)
//   rdata, rvalid   read data; rvalid is a 1-cycle pulse in standard mode and
//                   equals !empty in FWFT mode
//   full, empty     count == DEPTH / no word readable
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
//   count           words held, 0..DEPTH (FWFT: includes prefetched words)
//   overflow        1-cycle pulse after wen while full
//   underflow       1-cycle pulse after ren while empty
// All flags are registered and computed from the next-state count so they
// change in the same cycle as count.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned D_WIDTH  = 32,
  parameter int unsigned A_WIDTH  = 8,
  parameter int unsigned FWFT     = 0,
  parameter int          AF_LEVEL = (2 ** A_WIDTH) - 4,
  parameter int          AE_LEVEL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wen,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               ren,
  output logic [D_WIDTH-1:0] rdata,
  output logic               rvalid,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [A_WIDTH:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam int unsigned Depth = fifo_depth(A_WIDTH);
  localparam int unsigned PtrW  = fifo_ptr_width(A_WIDTH);
  localparam fifo_mode_e  Mode  = fifo_mode(FWFT);

  localparam logic [PtrW-1:0] CntFull = PtrW'(Depth);
  localparam logic [PtrW-1:0] AfLvl   = PtrW'(AF_LEVEL);
  localparam logic [PtrW-1:0] AeLvl   = PtrW'(AE_LEVEL);
  localparam logic [PtrW-1:0] One     = PtrW'(1);

  if (AF_LEVEL < 0 || AF_LEVEL > int'(Depth)) begin : g_af_range
    $error("sync_fifo_ctrl: AF_LEVEL must lie in 0..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > int'(Depth)) begin : g_ae_range
    $error("sync_fifo_ctrl: AE_LEVEL must lie in 0..DEPTH");
  end
  if (FWFT > 1) begin : g_mode_range
    $error("sync_fifo_ctrl: FWFT must be 0 or 1");
  end

  // Pointers carry a wrap bit; the low A_WIDTH bits address the RAM.
  logic [PtrW-1:0]    wptr_q, rptr_q;
  logic [PtrW-1:0]    count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               afull_q, afull_d;
  logic               aempty_q, aempty_d;
  logic               ovf_q, udf_q;
  logic               wr_acc, rd_acc;
  logic               ram_re;
  logic [D_WIDTH-1:0] ram_q;

  // Full blocks writes even with a simultaneous read: no pass-through.
  assign wr_acc = wen & ~full_q;
  // empty_q reflects "no word readable" in both modes, so this one term covers
  // both the standard read and the FWFT pop.
  assign rd_acc = ren & ~empty_q;

  always_comb begin
    count_d = count_q;
    if (wr_acc && !rd_acc) begin
      count_d = count_q + One;
    end else if (!wr_acc && rd_acc) begin
      count_d = count_q - One;
    end
  end

  assign full_d   = (count_d == CntFull);
  assign afull_d  = (count_d >= AfLvl);
  assign aempty_d = (count_d <= AeLvl);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr_q <= wptr_q + One;
      end
      if (ram_re) begin
        rptr_q <= rptr_q + One;
      end
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= wen & full_q;
      udf_q    <= ren & empty_q;
    end
  end

  sync_fifo_ram #(
    .D_WIDTH(D_WIDTH),
    .A_WIDTH(A_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wptr_q[A_WIDTH-1:0]),
    .wdata(wdata),
    .re   (ram_re),
    .raddr(rptr_q[A_WIDTH-1:0]),
    .rdata(ram_q)
  );

  if (Mode == FIFO_STD) begin : g_std
    logic rvalid_q;

    // The RAM read register doubles as rdata: it holds while re is low.
    assign ram_re  = rd_acc;
    assign empty_d = (count_d == '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
      end
    end

    assign rdata  = ram_q;
    assign rvalid = rvalid_q;
  end else begin : g_fwft
    // Two-stage prefetch: the RAM read register (mid) feeds the output
    // register (out). Both advance in the same cycle as a pop, so a stream of
    // pops sees no bubble while the RAM keeps supplying words.
    logic               mid_valid_q, mid_valid_d;
    logic               out_valid_q, out_valid_d;
    logic [D_WIDTH-1:0] out_q;
    logic               out_free, mid_move, mid_free;

    assign out_free    = ~out_valid_q | rd_acc;
    assign mid_move    = mid_valid_q & out_free;
    assign mid_free    = ~mid_valid_q | mid_move;
    assign ram_re      = (wptr_q != rptr_q) & mid_free;
    assign mid_valid_d = ram_re | (mid_valid_q & ~mid_move);
    assign out_valid_d = mid_move | (out_valid_q & ~rd_acc);
    assign empty_d     = ~out_valid_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        mid_valid_q <= 1'b0;
        out_valid_q <= 1'b0;
        out_q       <= '0;
      end else begin
        mid_valid_q <= mid_valid_d;
        out_valid_q <= out_valid_d;
        if (mid_move) begin
          out_q <= ram_q;
        end
      end
    end

    assign rdata  = out_q;
    assign rvalid = ~empty_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Three FIFOs share one stimulus stream: standard depth 8, FWFT depth 8 and
// standard depth 4. A queue-based model per instance predicts flags each
// cycle; write data goes into a per-instance expected queue that a separate
// monitor drains whenever a DUT presents a read word.
module tb_sync_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       wen;
  logic       ren;
  logic [7:0] wdata;

  logic [7:0] rdata_w [3];
  logic       rvalid_w[3];
  logic       full_w  [3];
  logic       empty_w [3];
  logic       af_w    [3];
  logic       ae_w    [3];
  logic       ovf_w   [3];
  logic       udf_w   [3];
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;

  sync_fifo_ctrl #(.D_WIDTH(8), .A_WIDTH(3), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(1)) u_std (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_w[0]), .rvalid(rvalid_w[0]), .full(full_w[0]), .empty(empty_w[0]),
    .almost_full(af_w[0]), .almost_empty(ae_w[0]), .count(cnt0),
    .overflow(ovf_w[0]), .underflow(udf_w[0])
  );

  sync_fifo_ctrl #(.D_WIDTH(8), .A_WIDTH(3), .FWFT(1), .AF_LEVEL(6), .AE_LEVEL(1)) u_fwft (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_w[1]), .rvalid(rvalid_w[1]), .full(full_w[1]), .empty(empty_w[1]),
    .almost_full(af_w[1]), .almost_empty(ae_w[1]), .count(cnt1),
    .overflow(ovf_w[1]), .underflow(udf_w[1])
  );

  sync_fifo_ctrl #(.D_WIDTH(8), .A_WIDTH(2), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_wrap (
    .clk(clk), .rst(rst), .wen(wen), .wdata(wdata), .ren(ren),
    .rdata(rdata_w[2]), .rvalid(rvalid_w[2]), .full(full_w[2]), .empty(empty_w[2]),
    .almost_full(af_w[2]), .almost_empty(ae_w[2]), .count(cnt2),
    .overflow(ovf_w[2]), .underflow(udf_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance configuration as seen by the model.
  int depth_m[3] = '{8, 8, 4};
  bit fwft_m [3] = '{1'b0, 1'b1, 1'b0};
  int af_m   [3] = '{6, 6, 3};
  int ae_m   [3] = '{1, 1, 1};

  // Model state: write edge of each stored word, expected data queue, and the
  // visible/pop edges of the last word popped (FWFT timing).
  int         wt   [3][$];
  logic [7:0] exq  [3][$];
  int         vprev[3];
  int         pprev[3];
  int         cyc;

  int e_count[3];
  bit e_full [3], e_empty[3], e_af[3], e_ae[3], e_ovf[3], e_udf[3], e_rv[3];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  // FWFT: a word reaches the prefetch stage one edge after it is written but
  // not before the previous word left that stage; it becomes visible one edge
  // later but not before the previous word was popped.
  function automatic int vis_time(input int i);
    int t;
    t = wt[i][0] + 1;
    if (vprev[i] > t) t = vprev[i];
    t = t + 1;
    if (pprev[i] > t) t = pprev[i];
    return t;
  endfunction

  task automatic step(input int i);
    int sz;
    bit vis, rd, wr;
    if (rst) begin
      wt[i].delete();
      exq[i].delete();
      vprev[i] = -100;
      pprev[i] = -100;
      e_count[i] = 0; e_full[i] = 1'b0; e_empty[i] = 1'b1; e_af[i] = 1'b0;
      e_ae[i] = 1'b1; e_ovf[i] = 1'b0; e_udf[i] = 1'b0; e_rv[i] = 1'b0;
      return;
    end
    sz  = wt[i].size();
    vis = (sz > 0) && (!fwft_m[i] || vis_time(i) <= cyc - 1);
    rd  = ren && vis;
    wr  = wen && (sz < depth_m[i]);
    e_ovf[i] = wen && (sz == depth_m[i]);
    e_udf[i] = ren && !vis;
    if (rd) begin
      if (fwft_m[i]) begin
        vprev[i] = vis_time(i);
        pprev[i] = cyc;
      end
      void'(wt[i].pop_front());
    end
    if (wr) begin
      wt[i].push_back(cyc);
      exq[i].push_back(wdata);
    end
    sz = wt[i].size();
    e_count[i] = sz;
    e_full[i]  = (sz == depth_m[i]);
    e_af[i]    = (sz >= af_m[i]);
    e_ae[i]    = (sz <= ae_m[i]);
    if (fwft_m[i]) begin
      e_empty[i] = !((sz > 0) && (vis_time(i) <= cyc));
      e_rv[i]    = !e_empty[i];
    end else begin
      e_empty[i] = (sz == 0);
      e_rv[i]    = rd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) step(i);
    cyc++;
    #1;
  endtask

  function automatic int cnt_of(input int i);
    if (i == 0) return int'(cnt0);
    if (i == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  // Per-cycle flag/count checker.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("count[%0d]", i), cnt_of(i), e_count[i]);
        chk($sformatf("full[%0d]", i), int'(full_w[i]), int'(e_full[i]));
        chk($sformatf("empty[%0d]", i), int'(empty_w[i]), int'(e_empty[i]));
        chk($sformatf("almost_full[%0d]", i), int'(af_w[i]), int'(e_af[i]));
        chk($sformatf("almost_empty[%0d]", i), int'(ae_w[i]), int'(e_ae[i]));
        chk($sformatf("overflow[%0d]", i), int'(ovf_w[i]), int'(e_ovf[i]));
        chk($sformatf("underflow[%0d]", i), int'(udf_w[i]), int'(e_udf[i]));
        chk($sformatf("rvalid[%0d]", i), int'(rvalid_w[i]), int'(e_rv[i]));
      end
    end
  end

  // Data monitor: standard mode on each rvalid pulse, FWFT on each pop.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        if (fwft_m[i] ? (rvalid_w[i] && ren) : rvalid_w[i]) begin
          if (exq[i].size() == 0) begin
            chk($sformatf("data_pending[%0d]", i), 0, 1);
          end else begin
            chk($sformatf("rdata[%0d]", i), int'(rdata_w[i]), int'(exq[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = 8'h00; cyc = 0;
    for (int i = 0; i < 3; i++) begin
      vprev[i] = -100;
      pprev[i] = -100;
    end
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) chk($sformatf("rst_rdata[%0d]", i), int'(rdata_w[i]), 0);

    // Fill the depth-8 FIFOs with 0..7, then one write too many.
    wen = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wdata = 8'(k);
      tick();
    end
    chk("fill_count", int'(cnt0), 8);
    chk("fill_full", int'(full_w[0]), 1);
    wdata = 8'hEE;
    tick();
    chk("ovf_pulse", int'(ovf_w[0]), 1);
    chk("ovf_count", int'(cnt0), 8);

    // Drain plus one extra read.
    wen = 1'b0; ren = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    chk("drain_empty", int'(empty_w[0]), 1);
    chk("udf_pulse", int'(udf_w[0]), 1);

    // Simultaneous write/read at a steady level, then at full and at empty.
    ren = 1'b0; wen = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wdata = 8'(8'h10 + k);
      tick();
    end
    ren = 1'b1;
    for (int k = 0; k < 10; k++) begin
      wdata = 8'(8'h20 + k);
      tick();
    end
    chk("steady_count", int'(cnt0), 4);
    ren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wdata = 8'(8'h40 + k);
      tick();
    end
    chk("refill_full", int'(full_w[0]), 1);
    ren = 1'b1; wdata = 8'h55;
    tick();
    chk("full_wr_rd_count", int'(cnt0), 7);
    wen = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    wen = 1'b1; wdata = 8'h66;
    tick();
    chk("empty_wr_rd_count", int'(cnt0), 1);
    chk("empty_wr_rd_udf", int'(udf_w[0]), 1);

    // Almost flags: from empty, almost_empty falls on 2nd write, almost_full
    // rises on 6th.
    ren = 1'b0; wen = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; wen = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wdata = 8'(8'h70 + k);
      tick();
      if (k == 1) chk("ae_after_1", int'(ae_w[0]), 1);
      if (k == 2) chk("ae_after_2", int'(ae_w[0]), 0);
      if (k == 5) chk("af_after_5", int'(af_w[0]), 0);
      if (k == 6) chk("af_after_6", int'(af_w[0]), 1);
    end

    // Reset with data stored and a read in flight.
    ren = 1'b1; wen = 1'b0;
    tick();
    rst = 1'b1; ren = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_count", int'(cnt0), 0);
    chk("mid_rst_empty", int'(empty_w[1]), 1);
    chk("mid_rst_rvalid", int'(rvalid_w[0]), 0);

    // FWFT head latency: visible two edges after the write.
    wen = 1'b1; wdata = 8'hA5;
    tick();
    wen = 1'b0;
    chk("fwft_empty_n", int'(empty_w[1]), 1);
    tick();
    chk("fwft_empty_n1", int'(empty_w[1]), 1);
    tick();
    chk("fwft_empty_n2", int'(empty_w[1]), 0);
    chk("fwft_head", int'(rdata_w[1]), 8'hA5);
    ren = 1'b1;
    tick();
    ren = 1'b0;

    // FWFT back-to-back pops of three words.
    wen = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      wdata = 8'(8'hB0 + k);
      tick();
    end
    wen = 1'b0;
    tick();
    tick();
    ren = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("fwft_burst_%0d", k), int'(rdata_w[1]), 8'hB0 + k);
      tick();
    end
    chk("fwft_burst_empty", int'(empty_w[1]), 1);
    ren = 1'b0;

    // Random interleaved traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      wen   = ($urandom_range(0, 99) < 55);
      ren   = ($urandom_range(0, 99) < 50);
      wdata = 8'($urandom);
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; wen = 1'b0; ren = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    ren = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
